// File: rtl/amm_arb_pkg.sv
// Shared types and constants for the Avalon-MM bus arbiters.
package amm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    ACK,
    RDWAIT
  } state_t;

  localparam logic [31:0] DEAD_DATA = 32'hDEAD_BEEF;
  localparam int unsigned MAX_REQ   = 8;

endpackage

// File: rtl/amm_rr_arbiter_rr_pick.sv
// Round-robin picker: first pending index searching upward from last+1, wrapping.
module rr_pick #(
  parameter int unsigned N_REQ = 2
) (
  input  logic [N_REQ-1:0]         i_pending,
  input  logic [$clog2(N_REQ)-1:0] i_last,
  output logic                     o_valid,
  output logic [$clog2(N_REQ)-1:0] o_idx
);

  localparam int unsigned IW = $clog2(N_REQ);

  always_comb begin
    int unsigned      j;
    logic [IW-1:0]    w_j;
    o_valid = 1'b0;
    o_idx   = '0;
    j       = 0;
    w_j     = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      j   = (32'(i_last) + k) % N_REQ;
      w_j = IW'(j);
      if (!o_valid && i_pending[w_j]) begin
        o_valid = 1'b1;
        o_idx   = w_j;
      end
    end
  end

endmodule

// File: rtl/amm_rr_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM slave among N_REQ requesters,
// one transaction at a time, with a per-transaction timeout.
module amm_rr_arbiter
  import amm_arb_pkg::*;
#(
  parameter int unsigned N_REQ          = 2,
  parameter int unsigned ADDR_WIDTH     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]    rq_address,
  input  logic [N_REQ-1:0]                    rq_read,
  input  logic [N_REQ-1:0]                    rq_write,
  input  logic [N_REQ-1:0][31:0]              rq_writedata,
  output logic [N_REQ-1:0]                    rq_waitrequest,
  output logic [31:0]                         rq_readdata,
  output logic [N_REQ-1:0]                    rq_readdatavalid,
  output logic [ADDR_WIDTH-1:0]               avm_address,
  output logic                                avm_read,
  output logic                                avm_write,
  output logic [31:0]                         avm_writedata,
  input  logic                                avm_waitrequest,
  input  logic [31:0]                         avm_readdata,
  input  logic                                avm_readdatavalid,
  output logic                                err_timeout,
  output logic [$clog2(N_REQ)-1:0]            err_id
);

  localparam int unsigned    IW      = $clog2(N_REQ);
  localparam int unsigned    CW      = $clog2(TIMEOUT_CYCLES + 2);
  // Fires on the TIMEOUT_CYCLES-th cycle after CMD entry so the abort is visible exactly TIMEOUT_CYCLES later.
  localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t                r_state, w_state;
  logic [IW-1:0]         r_last, w_last, r_gnt, w_gnt;
  logic                  r_is_rd, w_is_rd, r_abort, w_abort;
  logic [CW-1:0]         r_cnt, w_cnt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr;
  logic [31:0]           r_wdata, w_wdata, r_rdata, w_rdata;
  logic                  r_avm_rd, w_avm_rd, r_avm_wr, w_avm_wr;
  logic [N_REQ-1:0]      r_wait, w_wait, r_rvalid, w_rvalid;
  logic                  r_err, w_err;
  logic [IW-1:0]         r_err_id, w_err_id;
  logic [N_REQ-1:0]      w_pending;
  logic                  w_pick_vld, w_timeout;
  logic [IW-1:0]         w_pick;

  assign w_pending = rq_read | rq_write;
  assign w_timeout = (r_cnt >= TO_LAST);

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .i_pending (w_pending),
    .i_last    (r_last),
    .o_valid   (w_pick_vld),
    .o_idx     (w_pick)
  );

  always_comb begin
    w_state  = r_state;
    w_last   = r_last;
    w_gnt    = r_gnt;
    w_is_rd  = r_is_rd;
    w_abort  = r_abort;
    w_cnt    = (r_state == IDLE) ? r_cnt : r_cnt + 1'b1;
    w_addr   = r_addr;
    w_wdata  = r_wdata;
    w_avm_rd = r_avm_rd;
    w_avm_wr = r_avm_wr;
    w_wait   = '1;
    w_rvalid = '0;
    w_rdata  = r_rdata;
    w_err    = 1'b0;
    w_err_id = r_err_id;
    unique case (r_state)
      IDLE: begin
        // No grant while a read response is still pulsing: the next decision lands at v+2.
        if (w_pick_vld && !(|r_rvalid)) begin
          w_gnt    = w_pick;
          w_last   = w_pick;
          w_is_rd  = rq_read[w_pick];
          w_addr   = rq_address[w_pick];
          w_wdata  = rq_writedata[w_pick];
          w_avm_rd = rq_read[w_pick];
          w_avm_wr = !rq_read[w_pick];
          w_abort  = 1'b0;
          w_cnt    = '0;
          w_state  = CMD;
        end
      end
      CMD: begin
        if (!avm_waitrequest || w_timeout) begin
          w_avm_rd      = 1'b0;
          w_avm_wr      = 1'b0;
          w_wait[r_gnt] = 1'b0;
          w_state       = ACK;
          if (avm_waitrequest) begin
            w_abort  = 1'b1;
            w_err    = 1'b1;
            w_err_id = r_gnt;
          end
        end
      end
      ACK: begin
        if (!r_is_rd || r_abort) begin
          w_state = IDLE;
        end else if (avm_readdatavalid) begin
          w_rdata         = avm_readdata;
          w_rvalid[r_gnt] = 1'b1;
          w_state         = IDLE;
        end else begin
          w_state = RDWAIT;
        end
      end
      RDWAIT: begin
        if (avm_readdatavalid) begin
          w_rdata         = avm_readdata;
          w_rvalid[r_gnt] = 1'b1;
          w_state         = IDLE;
        end else if (w_timeout) begin
          w_rdata         = DEAD_DATA;
          w_rvalid[r_gnt] = 1'b1;
          w_err           = 1'b1;
          w_err_id        = r_gnt;
          w_state         = IDLE;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_last   <= IW'(N_REQ - 1);
      r_gnt    <= '0;
      r_is_rd  <= 1'b0;
      r_abort  <= 1'b0;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_avm_rd <= 1'b0;
      r_avm_wr <= 1'b0;
      r_wait   <= '1;
      r_rvalid <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_err_id <= '0;
    end else begin
      r_state  <= w_state;
      r_last   <= w_last;
      r_gnt    <= w_gnt;
      r_is_rd  <= w_is_rd;
      r_abort  <= w_abort;
      r_cnt    <= w_cnt;
      r_addr   <= w_addr;
      r_wdata  <= w_wdata;
      r_avm_rd <= w_avm_rd;
      r_avm_wr <= w_avm_wr;
      r_wait   <= w_wait;
      r_rvalid <= w_rvalid;
      r_rdata  <= w_rdata;
      r_err    <= w_err;
      r_err_id <= w_err_id;
    end
  end

  assign rq_waitrequest   = r_wait;
  assign rq_readdata      = r_rdata;
  assign rq_readdatavalid = r_rvalid;
  assign avm_address      = r_addr;
  assign avm_read         = r_avm_rd;
  assign avm_write        = r_avm_wr;
  assign avm_writedata    = r_wdata;
  assign err_timeout      = r_err;
  assign err_id           = r_err_id;

endmodule

// File: tb/tb_amm_rr_arbiter.sv
// Directed bench for amm_rr_arbiter with a behavioural Avalon-MM slave.
module tb_amm_rr_arbiter;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [1:0][1:0]  rq_address;
  logic [1:0]       rq_read, rq_write;
  logic [1:0][31:0] rq_writedata;
  logic [1:0]       rq_waitrequest, rq_readdatavalid;
  logic [31:0]      rq_readdata;
  logic [1:0]       avm_address;
  logic             avm_read, avm_write;
  logic [31:0]      avm_writedata;
  logic             avm_waitrequest;
  logic [31:0]      avm_readdata;
  logic             avm_readdatavalid;
  logic             err_timeout;
  logic [0:0]       err_id;

  amm_rr_arbiter #(.N_REQ(2), .ADDR_WIDTH(2), .TIMEOUT_CYCLES(16)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .rq_address        (rq_address),
    .rq_read           (rq_read),
    .rq_write          (rq_write),
    .rq_writedata      (rq_writedata),
    .rq_waitrequest    (rq_waitrequest),
    .rq_readdata       (rq_readdata),
    .rq_readdatavalid  (rq_readdatavalid),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .err_timeout       (err_timeout),
    .err_id            (err_id)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Slave model: sl_wait wait cycles per command, read data sl_vdelay cycles after accept.
  int          sl_wait = 0, sl_vdelay = 1;
  bit          sl_novalid = 1'b0, sl_stuck = 1'b0;
  logic [31:0] ram [4];
  int          wcnt, rd_cnt;
  logic [31:0] rd_data;

  initial begin
    avm_waitrequest   = 1'b1;
    avm_readdata      = '0;
    avm_readdatavalid = 1'b0;
    ram[0] = '0; ram[1] = '0; ram[2] = 32'h1234_5678; ram[3] = '0;
    wcnt = 0; rd_cnt = 0; rd_data = '0;
    forever begin
      @(negedge clk);
      avm_readdatavalid = 1'b0;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = rd_data;
        end
      end
      if (avm_read || avm_write) begin
        if (sl_stuck || wcnt < sl_wait) begin
          avm_waitrequest = 1'b1;
          wcnt++;
        end else begin
          avm_waitrequest = 1'b0;
          wcnt = 0;
          if (avm_write) ram[avm_address] = avm_writedata;
          else if (!sl_novalid) begin
            rd_cnt  = sl_vdelay;
            rd_data = ram[avm_address];
          end
        end
      end else begin
        avm_waitrequest = 1'b1;
        wcnt = 0;
      end
    end
  end

  int          t_cmd, t_ack, t_rv, t_err, t_set, n_wcmd, nerr;
  int          nwl [2];
  int          nrv [2];
  logic [31:0] rv_data;
  logic [0:0]  eid;

  // Observe ncyc cycles; each requester drops its command once accepted.
  task automatic mon(input int ncyc);
    bit ii;
    t_cmd = -1; t_ack = -1; t_rv = -1; t_err = -1; n_wcmd = 0; nerr = 0;
    nwl[0] = 0; nwl[1] = 0; nrv[0] = 0; nrv[1] = 0; rv_data = '0; eid = '0;
    repeat (ncyc) begin
      @(negedge clk);
      if ((avm_read || avm_write) && t_cmd < 0) t_cmd = cyc;
      if (avm_write) n_wcmd++;
      for (int i = 0; i < 2; i++) begin
        ii = 1'(i);
        if (!rq_waitrequest[ii]) begin
          nwl[i]++; t_ack = cyc; rq_read[ii] = 1'b0; rq_write[ii] = 1'b0;
        end
        if (rq_readdatavalid[ii]) begin
          nrv[i]++; rv_data = rq_readdata; t_rv = cyc;
        end
      end
      if (err_timeout) begin
        nerr++; eid = err_id; t_err = cyc;
      end
    end
  endtask

  int g_id [8];
  int g_t  [8];
  int ng, c0, c1;

  initial begin
    reset_n = 1'b0;
    rq_read = '0; rq_write = '0; rq_address = '0; rq_writedata = '0;
    repeat (3) @(negedge clk);
    chk("rst_waitreq", 32'(rq_waitrequest), 32'h3);
    chk("rst_rvalid", 32'(rq_readdatavalid), 32'h0);
    chk("rst_rdata", rq_readdata, 32'h0);
    chk("rst_avm_rw", 32'({avm_read, avm_write}), 32'h0);
    chk("rst_avm_addr_wd", avm_writedata | 32'(avm_address), 32'h0);
    chk("rst_err", 32'({err_timeout, err_id}), 32'h0);
    reset_n = 1'b1;

    // Both requesters write continuously: grants alternate starting at 0.
    sl_wait = 0; sl_vdelay = 1;
    for (int k = 0; k < 8; k++) begin g_id[k] = -1; g_t[k] = 0; end
    rq_address[0] = 2'd0; rq_address[1] = 2'd3;
    rq_writedata[0] = 32'h100; rq_writedata[1] = 32'h200;
    rq_write = 2'b11; ng = 0; c0 = 0; c1 = 0;
    for (int k = 0; k < 80 && ng < 8; k++) begin
      @(negedge clk);
      if (!rq_waitrequest[0]) begin
        g_id[ng] = 0; g_t[ng] = cyc; ng++; c0++;
        if (c0 == 4) rq_write[0] = 1'b0; else rq_writedata[0] = 32'h100 + 32'(c0);
      end
      if (!rq_waitrequest[1] && ng < 8) begin
        g_id[ng] = 1; g_t[ng] = cyc; ng++; c1++;
        if (c1 == 4) rq_write[1] = 1'b0; else rq_writedata[1] = 32'h200 + 32'(c1);
      end
    end
    rq_write = '0;
    chk("wr_grants", 32'(ng), 32'd8);
    for (int k = 0; k < 8; k++) chk($sformatf("wr_grant%0d", k), 32'(g_id[k]), 32'(k % 2));
    chk("wr_period01", 32'(g_t[1] - g_t[0]), 32'd3);
    chk("wr_period12", 32'(g_t[2] - g_t[1]), 32'd3);
    chk("wr_ram0", ram[0], 32'h103);
    chk("wr_ram3", ram[3], 32'h203);

    // Single read, requester 0, 5 wait cycles and 5-cycle data latency.
    repeat (2) @(negedge clk);
    sl_wait = 5; sl_vdelay = 5;
    rq_address[0] = 2'd2; rq_read[0] = 1'b1; t_set = cyc;
    mon(25);
    chk("rd_cmd_lat", 32'(t_cmd - t_set), 32'd1);
    chk("rd_ack_lat", 32'(t_ack - t_cmd), 32'd6);
    chk("rd_wait_low", 32'(nwl[0]), 32'd1);
    chk("rd_data", rv_data, 32'h1234_5678);
    chk("rd_rv_lat", 32'(t_rv - t_cmd), 32'd11);
    chk("rd_rv_cnt", 32'({nrv[1][7:0], nrv[0][7:0]}), 32'h0001);
    chk("rd_no_err", 32'(nerr), 32'd0);

    // Write 0xCAFE from 0, then read it back from 1 issuing read+write together.
    sl_wait = 0; sl_vdelay = 1;
    rq_address[0] = 2'd1; rq_writedata[0] = 32'h0000_CAFE; rq_write[0] = 1'b1;
    mon(8);
    chk("cafe_wr_ack", 32'(nwl[0]), 32'd1);
    chk("cafe_ram", ram[1], 32'h0000_CAFE);
    rq_address[1] = 2'd1; rq_writedata[1] = 32'h5555_5555;
    rq_read[1] = 1'b1; rq_write[1] = 1'b1;
    mon(10);
    chk("cafe_rd_data", rv_data, 32'h0000_CAFE);
    chk("cafe_rv_cnt", 32'({nrv[1][7:0], nrv[0][7:0]}), 32'h0100);
    chk("cafe_as_read", 32'(n_wcmd), 32'd0);
    chk("cafe_rv_lat", 32'(t_rv - t_cmd), 32'd2);

    // Slave never answers the read: DEAD_BEEF 16 cycles after CMD entry.
    sl_novalid = 1'b1;
    rq_address[1] = 2'd2; rq_read[1] = 1'b1;
    mon(30);
    chk("to_data", rv_data, 32'hDEAD_BEEF);
    chk("to_rv_lat", 32'(t_rv - t_cmd), 32'd16);
    chk("to_rv_cnt", 32'({nrv[1][7:0], nrv[0][7:0]}), 32'h0100);
    chk("to_err_cnt", 32'(nerr), 32'd1);
    chk("to_err_id", 32'(eid), 32'd1);
    chk("to_err_when", 32'(t_err - t_rv), 32'd0);
    sl_novalid = 1'b0; sl_vdelay = 2;
    rq_address[0] = 2'd1; rq_read[0] = 1'b1;
    mon(12);
    chk("after_to_data", rv_data, 32'h0000_CAFE);
    chk("after_to_rv", 32'({nrv[1][7:0], nrv[0][7:0]}), 32'h0001);
    chk("after_to_no_err", 32'(nerr), 32'd0);
    chk("err_id_held", 32'(err_id), 32'd1);

    // Reset during RDWAIT; the slave's late readdatavalid must be ignored.
    sl_vdelay = 10;
    rq_address[0] = 2'd2; rq_read[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("rr_ack", 32'(rq_waitrequest), 32'h2);
    rq_read[0] = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rr_waitreq", 32'(rq_waitrequest), 32'h3);
    chk("rr_rdata", rq_readdata, 32'h0);
    chk("rr_avm", 32'({avm_read, avm_write, avm_address}), 32'h0);
    chk("rr_err_id", 32'({err_timeout, err_id}), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    mon(15);
    chk("rr_late_rv", 32'(nrv[0] + nrv[1]), 32'd0);
    chk("rr_no_cmd", 32'(t_cmd), 32'hFFFF_FFFF);

    // Waitrequest stuck high: write dropped after 16 cycles, one accept pulse.
    sl_stuck = 1'b1;
    rq_address[0] = 2'd3; rq_writedata[0] = 32'h55; rq_write[0] = 1'b1;
    mon(30);
    chk("stuck_ack_cnt", 32'(nwl[0]), 32'd1);
    chk("stuck_ack_lat", 32'(t_ack - t_cmd), 32'd16);
    chk("stuck_err_cnt", 32'(nerr), 32'd1);
    chk("stuck_err_when", 32'(t_err - t_ack), 32'd0);
    chk("stuck_err_id", 32'(eid), 32'd0);
    chk("stuck_cmd_off", 32'({avm_read, avm_write}), 32'h0);
    chk("stuck_ram", ram[3], 32'h203);
    sl_stuck = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/amm_rr_arbiter.md
# amm_rr_arbiter

Round-robin controller that shares one Avalon-MM slave port between `N_REQ` Avalon-MM requesters (PID cores, register loaders, debug access). It arbitrates, registers and forwards one transaction at a time, holds the bus until a read's `readdatavalid` returns, and routes the response to the owning requester. A per-transaction timeout keeps a hung slave from locking the bus.

## Interface
- `N_REQ`, 2: number of requesters (2..8)
- `ADDR_WIDTH`, 2: slave word-address width
- `TIMEOUT_CYCLES`, 64: max cycles in CMD or RDWAIT before abort (≥ 8)
- `clk`  in  1  single clock, all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `rq_address`  in  [N_REQ][ADDR_WIDTH]  per-requester address
- `rq_read`, `rq_write`  in  [N_REQ]  per-requester command, held until accepted
- `rq_writedata`  in  [N_REQ][32]  per-requester write data
- `rq_waitrequest`  out  [N_REQ]  low for exactly one cycle = command accepted
- `rq_readdata`  out  32  read data, shared by all requesters
- `rq_readdatavalid`  out  [N_REQ]  one-cycle pulse to owner of the read
- `avm_address`  out  ADDR_WIDTH
- `avm_read`, `avm_write`  out  1
- `avm_writedata`  out  32
- `avm_waitrequest`  in  1
- `avm_readdata`  in  32
- `avm_readdatavalid`  in  1
- `err_timeout`  out  1  one-cycle pulse on abort
- `err_id`  out  $clog2(N_REQ)  requester aborted, held until next abort

## Operation
- States: IDLE, CMD, ACK, RDWAIT.
- IDLE: requester i is pending if `rq_read[i] | rq_write[i]`. Pick first pending index searching from `last+1` mod N_REQ; latch index, address, read/write, writedata; `last` := index; → CMD. Nothing pending: stay.
- A requester asserting read and write together is treated as read.
- CMD: drive `avm_*` from latched copy. On a cycle with `avm_waitrequest`=0 → ACK.
- ACK: `avm_read/write`=0; `rq_waitrequest[g]`=0 (all others stay 1). Write → IDLE. Read → RDWAIT, unless `avm_readdatavalid`=1 this cycle, which is handled as in RDWAIT.
- RDWAIT: on `avm_readdatavalid`, register `avm_readdata` into `rq_readdata`, pulse `rq_readdatavalid[g]` the next cycle; → IDLE.
- Timeout: cycle counter clears on CMD entry and counts in CMD, ACK and RDWAIT. When it reaches TIMEOUT_CYCLES:
  - In CMD: drop command, go to ACK (requester completes), pulse `err_timeout`.
  - In RDWAIT: return `rq_readdata` = 32'hDEAD_BEEF with `rq_readdatavalid[g]`, pulse `err_timeout`, → IDLE.
- `avm_readdatavalid` seen in IDLE or CMD (stale, after abort) is ignored.
- Reset mid-transaction: all state and outputs go to reset values immediately. An in-flight read is discarded. `last` := N_REQ-1, so requester 0 wins first.

## Timing
- Reset values:
  - `rq_waitrequest` all 1; `rq_readdatavalid` 0; `rq_readdata` 0.
  - `avm_read`/`avm_write` 0; `avm_address`/`avm_writedata` 0.
  - `err_timeout` 0; `err_id` 0; state IDLE.
- All outputs are registered; there is no combinational path from `rq_*` or `avm_*` inputs to outputs.
- Request seen in IDLE at cycle t: `avm_read/write` asserted at t+1.
- Slave accepts at cycle a: `rq_waitrequest[g]` low at a+1.
- `avm_readdatavalid` at cycle v: `rq_readdatavalid[g]` and `rq_readdata` at v+1. Earliest next grant decision in IDLE at v+2.
- Write, zero-wait slave: 3 cycles per transaction (IDLE, CMD, ACK).
- Only one transaction is outstanding; no pipelining.

## Structure
- Package `amm_arb_pkg`:
  - `state_t` enum (IDLE, CMD, ACK, RDWAIT)
  - `DEAD_DATA` = 32'hDEAD_BEEF
  - `MAX_REQ` = 8
- Sub-module `rr_pick`: combinational. Inputs: pending vector, last index. Outputs: valid, chosen index. Kept separate so it can be reused by the other bus arbiters.

## Test plan
- Single read, requester 0, slave with 5-cycle waitrequest and 5-cycle valid delay, ram[2]=32'h1234_5678 -> `rq_readdata`=32'h1234_5678 with `rq_readdatavalid[0]` pulse; `rq_waitrequest[0]` low exactly one cycle.
- Requesters 0 and 1 both write continuously -> `avm` sees grants alternating 0,1,0,1. Neither requester waits more than one foreign transaction.
- Write to addr 1 of 32'hCAFE then read addr 1 from the other requester -> reads 32'hCAFE. Only requester 1 gets `rq_readdatavalid`.
- Slave never returns readdatavalid, TIMEOUT_CYCLES=16 -> 32'hDEAD_BEEF returned 16 cycles after CMD entry. `err_timeout` pulses, `err_id`=g, and the next request is served normally.
- `reset_n` low during RDWAIT -> outputs at reset values in the same cycle. A late `avm_readdatavalid` after reset produces no `rq_readdatavalid`.
- Slave with `avm_waitrequest` stuck high -> command dropped at timeout. `rq_waitrequest[g]` pulses low once and `err_timeout`=1.
